// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile write-port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default widths, FSM state encoding and the 2-way
// round-robin pick used by rr_arb2.
package regfile_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;

  // Write-port owner: normal arbitration or the zero-fill sequencer.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // One-hot grant for two requesters. On a tie the requester that did not
  // win last time is picked; otherwise the lone requester (if any) wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic       last_grant);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/regfile_wport_arb_rr_arb2.sv
// 2-way round-robin grant, purely combinational.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller qualifies gnt with its own enable.
//
// Ports:
//   req[1:0]   - request vector, bit N = requester N
//   last_grant - id of the requester granted most recently
//   gnt[1:0]   - one-hot grant (all zero when no request)
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = rr_pick(req, last_grant);
  end

endmodule

// File: rtl/regfile_wport_arb.sv
// Shares one regfile write port between two requesters (round-robin) and a
// zero-fill clear sequencer; the port is driven from registers.
// Latency: transfer in cycle N -> rf_wen/rf_waddr/rf_wdata in cycle N+1.
// Backpressure: reqN_ready is combinational; both deasserted in reset, while
//   clearing, and in the cycle clr_start is seen.
//
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   reqN_valid/addr/data/ready     - requester N write handshake (N = 0,1)
//   clr_start                      - one-cycle pulse starting a clear
//   clr_busy                       - high while the clear sequence runs
//   rf_wen/rf_waddr/rf_wdata       - registered regfile write port
//   last_grant                     - id of most recently granted requester
//
// Build option: define RF_ZERO_PROTECT_EN to suppress requester writes to
// address 0 (handshake still completes); clear writes are unaffected.
module regfile_wport_arb
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              last_grant
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NREG - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              xfer0;
  logic              xfer1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wen;

  assign req = {req1_valid, req0_valid};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // A clr_start seen in IDLE wins over any requester in the same cycle.
  assign arb_en     = !reset && (state == IDLE) && !clr_start;
  assign req0_ready = arb_en & gnt[0];
  assign req1_ready = arb_en & gnt[1];

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign xfer  = xfer0 | xfer1;

  // gnt is one-hot, so only the winner's payload needs selecting.
  assign sel_addr = xfer1 ? req1_addr : req0_addr;
  assign sel_data = xfer1 ? req1_data : req0_data;

`ifdef RF_ZERO_PROTECT_EN
  // r0 is hardwired zero in the datapath: swallow requester writes to it.
  assign sel_wen = (sel_addr != '0);
`else
  assign sel_wen = 1'b1;
`endif

  assign clr_busy = (state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= 1'b1;
    end else begin
      // Default: no write next cycle, address/data hold.
      rf_wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (xfer) begin
            rf_wen     <= sel_wen;
            rf_waddr   <= sel_addr;
            rf_wdata   <= sel_data;
            last_grant <= xfer1;
          end
        end
        CLEAR: begin
          // clr_start is ignored here; the sweep always runs to completion.
          rf_wen   <= 1'b1;
          rf_waddr <= clr_cnt;
          rf_wdata <= '0;
          if (clr_cnt == CNT_LAST) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
